// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO over a 1r1w sync RAM with a 2-entry output buffer.
// Define RAM_FIFO_CTRL_BYPASS_EN to let beats skip the RAM while it is empty.
module ram_fifo_ctrl #(
  parameter int width_p = 8,
  parameter int depth_p = 512,
  localparam int aw_lp = (depth_p > 1) ? $clog2(depth_p) : 1,
  localparam int cw_lp = $clog2(depth_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               ram_wr_valid_o,
  output logic [aw_lp-1:0]   ram_wr_addr_o,
  output logic [width_p-1:0] ram_wr_data_o,
  output logic               ram_rd_valid_o,
  output logic [aw_lp-1:0]   ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i
);

  logic [aw_lp-1:0]   wr_ptr;
  logic [aw_lp-1:0]   rd_ptr;
  logic [cw_lp-1:0]   ram_count;
  logic [1:0]         buf_cnt;
  logic               rd_inflight;
  logic [width_p-1:0] head;
  logic [width_p-1:0] second;

  logic               accept;
  logic               pop;
  logic               issue;
  logic               bypass;
  logic               ram_wr;
  logic               incoming;
  logic [1:0]         cnt_after;
  logic [2:0]         occ;
  logic [width_p-1:0] in_data;

  function automatic logic [aw_lp-1:0] wrap_inc(
    input logic [aw_lp-1:0] p
  );
    return (p == aw_lp'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o   = ram_count < cw_lp'(depth_p);
  assign valid_o   = buf_cnt != 2'd0;
  assign data_o    = head;
  assign accept    = valid_i & ready_o;
  assign pop       = valid_o & ready_i;
  assign cnt_after = buf_cnt - {1'b0, pop};
  assign occ       = {1'b0, cnt_after}
                   + {2'b00, rd_inflight};
  assign issue     = (ram_count != '0)
                   & (occ < 3'd2);

`ifdef RAM_FIFO_CTRL_BYPASS_EN
  // Only when nothing older sits in RAM or in flight.
  assign bypass = accept
                & (ram_count == '0)
                & ~rd_inflight
                & (cnt_after != 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign ram_wr   = accept & ~bypass;
  assign incoming = rd_inflight | bypass;
  assign in_data  = rd_inflight ? ram_rd_data_i
                                : data_i;

  assign ram_wr_valid_o = ram_wr;
  assign ram_wr_addr_o  = wr_ptr;
  assign ram_wr_data_o  = data_i;
  assign ram_rd_valid_o = issue;
  assign ram_rd_addr_o  = rd_ptr;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= issue;
      if (ram_wr) wr_ptr <= wrap_inc(wr_ptr);
      if (issue)  rd_ptr <= wrap_inc(rd_ptr);
      unique case (1'b1)
        ram_wr & ~issue: ram_count <= ram_count + 1'b1;
        issue & ~ram_wr: ram_count <= ram_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      buf_cnt <= 2'd0;
      head    <= '0;
      second  <= '0;
    end else begin
      if (pop && buf_cnt == 2'd2) head <= second;
      if (incoming) begin
        if (cnt_after == 2'd0) head <= in_data;
        else                   second <= in_data;
      end
      buf_cnt <= cnt_after + {1'b0, incoming};
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed + random bench with a queue model of the FIFO.
// Includes a behavioural 1r1w sync RAM; honours RAM_FIFO_CTRL_BYPASS_EN.
module tb_ram_fifo_ctrl;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = $clog2(D);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk_i    = 1'b0;
  logic          reset_ni = 1'b1;
  logic          valid_i  = 1'b0;
  logic [W-1:0]  data_i   = '0;
  logic          ready_i  = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          ram_wr_valid_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [W-1:0]  ram_wr_data_o;
  logic          ram_rd_valid_o;
  logic [AW-1:0] ram_rd_addr_o;
  logic [W-1:0]  ram_rd_data_i = '0;

  logic [W-1:0]  mem [D];

  ram_fifo_ctrl #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .ready_i(ready_i),
    .ram_wr_valid_o(ram_wr_valid_o),
    .ram_wr_addr_o(ram_wr_addr_o),
    .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_valid_o(ram_rd_valid_o),
    .ram_rd_addr_o(ram_rd_addr_o),
    .ram_rd_data_i(ram_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (ram_wr_valid_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_valid_o) ram_rd_data_i <= mem[ram_rd_addr_o];
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] q[$];
  int nwr = 0;
  int nrd = 0;
  logic p_valid = 1'b0;
  logic p_ready = 1'b0;
  logic [W-1:0] p_data = '0;
  logic s_valid, s_acc, s_pop, s_ready, s_wr, s_rd;
  logic [W-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update model, return just after posedge.
  task automatic step();
    logic [W-1:0] front;
    @(negedge clk_i);
    s_valid = valid_o;
    s_data  = data_o;
    s_ready = ready_o;
    s_wr    = ram_wr_valid_o;
    s_rd    = ram_rd_valid_o;
    s_acc   = valid_i & ready_o;
    s_pop   = valid_o & ready_i;
    if (p_valid && !p_ready) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_data", data_o, p_data);
    end
    if (s_pop) begin
      chk("pop_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        front = q.pop_front();
        chk("pop_data", data_o, front);
      end
    end
    if (s_acc) begin
      q.push_back(data_i);
      chk("capacity", 32'(q.size() <= D + 2), 1);
    end
`ifndef RAM_FIFO_CTRL_BYPASS_EN
    chk("wr_en", ram_wr_valid_o, s_acc);
`else
    if (ram_wr_valid_o) chk("wr_en_acc", s_acc, 1);
`endif
    if (ram_wr_valid_o) begin
      chk("wr_addr", ram_wr_addr_o, nwr % D);
      chk("wr_data", ram_wr_data_o, data_i);
      nwr++;
    end
    if (ram_rd_valid_o) begin
      chk("rd_addr", ram_rd_addr_o, nrd % D);
      chk("rd_after_wr", 32'(nrd < nwr), 1);
      nrd++;
    end
    p_valid = valid_o;
    p_ready = ready_i;
    p_data  = data_o;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int k, first, last, npop;
    logic vld [10];
    logic [W-1:0] dat [10];

    #1 reset_ni = 1'b0;
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_wr", ram_wr_valid_o, 0);
    chk("rst_rd", ram_rd_valid_o, 0);
    @(posedge clk_i);
    #1 reset_ni = 1'b1;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_ready", s_ready, 1);
      chk("idle_valid", s_valid, 0);
      chk("idle_data", s_data, 0);
      chk("idle_wr", s_wr, 0);
      chk("idle_rd", s_rd, 0);
    end

    // Three back-to-back beats: latency and order
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      valid_i = (c < 3);
      data_i  = W'(8'h11 * (c + 1));
      step();
      vld[c] = s_valid;
      dat[c] = s_data;
    end
    valid_i = 1'b0;
    first = -1;
    for (int c = 0; c < 10; c++)
      if (vld[c] && first < 0) first = c;
    chk("t2_latency", first, LAT);
    for (int j = 0; j < 3; j++) begin
      chk("t2_seq_valid", vld[LAT + j], 1);
      chk("t2_seq_data", dat[LAT + j], 8'h11 * (j + 1));
    end
    chk("t2_drained", q.size(), 0);

    // Fill with consumer stalled
    ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      valid_i = (k < 8);
      data_i  = W'(k);
      step();
      if (s_acc) k++;
    end
    valid_i = 1'b0;
    chk("t3_accepted", k, D + 2);
    chk("t3_full_ready", ready_o, 0);
    ready_i = 1'b1;
    npop = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_pop) npop++;
    end
    chk("t3_popped", npop, D + 2);
    chk("t3_empty", q.size(), 0);
    chk("t3_ready_back", ready_o, 1);

    // Streaming: one beat per cycle once filled
    k = 0; npop = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      valid_i = (k < 3 * D);
      data_i  = W'(8'h40 + k);
      step();
      if (s_acc) k++;
      if (s_pop) begin
        if (first < 0) first = c;
        last = c;
        npop++;
      end
    end
    valid_i = 1'b0;
    chk("t4_accepted", k, 3 * D);
    chk("t4_popped", npop, 3 * D);
    chk("t4_back_to_back", last - first, 3 * D - 1);

    // Random valid / ready
    for (int c = 0; c < 300; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = W'($urandom);
      ready_i = $urandom_range(0, 1);
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("t5_drained", q.size(), 0);

    // Reset with data queued
    ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      valid_i = 1'b1;
      data_i  = W'(8'hC1 + k);
      step();
      if (s_acc) k++;
    end
    valid_i = 1'b0;
    chk("t6_queued", k, 5);
    reset_ni = 1'b0;
    #1;
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_data", data_o, 0);
    chk("t6_rst_ready", ready_o, 1);
    q.delete();
    nwr = 0;
    nrd = 0;
    p_valid = 1'b0;
    repeat (2) step();
    reset_ni = 1'b1;
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    data_i   = 8'hAA;
    step();
    chk("t6_acc", s_acc, 1);
    valid_i = 1'b0;
    npop = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_pop) npop++;
    end
    chk("t6_single", npop, 1);
    chk("t6_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
